// File: rtl/top_one_neuron.sv
// Single-neuron dot-product datapath: ROM read, operand push, multiply-accumulate.
// Optional macro ONE_NEURON_RELU_EN clamps negative results on mac_out to zero.
module top_one_neuron #(
  parameter int N_INPUTS = 16,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 18,
  parameter int W_EVEN   = 3,
  parameter int W_ODD    = -1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_en,
  input  logic             mac_en,
  input  logic             mem_en,
  output logic [ACC_W-1:0] mac_out
);

  localparam int AW   = $clog2(N_INPUTS + 1);
  localparam int PW   = 2 * DATA_W;
  localparam logic [AW-1:0] LAST = AW'(N_INPUTS);

  // Input ROM: x[i] = i + 1
  function automatic logic signed [DATA_W-1:0] rom_x(input logic [AW-1:0] a);
    return DATA_W'(32'(a) + 32'd1);
  endfunction

  // Weight ROM: alternating even/odd weights
  function automatic logic signed [DATA_W-1:0] rom_w(input logic [AW-1:0] a);
    if (a[0]) begin
      return DATA_W'(W_ODD);
    end else begin
      return DATA_W'(W_EVEN);
    end
  endfunction

  logic [AW-1:0]              addr_r;
  logic                       valid1_r;
  logic                       valid2_r;
  logic signed [DATA_W-1:0]   rd_x_r;
  logic signed [DATA_W-1:0]   rd_w_r;
  logic signed [DATA_W-1:0]   x_reg_r;
  logic signed [DATA_W-1:0]   w_reg_r;
  logic        [ACC_W-1:0]    acc_r;
  logic signed [PW-1:0]       prod_s;
  logic        [ACC_W-1:0]    prod_ext_s;

  // Product of the operand registers, sign-extended to accumulator width
  always_comb begin
    prod_s     = x_reg_r * w_reg_r;
    prod_ext_s = {{(ACC_W-PW){prod_s[PW-1]}}, prod_s};
  end

  // Stage 1: address counter saturates at N_INPUTS so no reads follow the last one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r   <= '0;
      valid1_r <= 1'b0;
      rd_x_r   <= '0;
      rd_w_r   <= '0;
    end else if (mem_en && (addr_r < LAST)) begin
      rd_x_r   <= rom_x(addr_r);
      rd_w_r   <= rom_w(addr_r);
      valid1_r <= 1'b1;
      addr_r   <= addr_r + AW'(1);
    end else begin
      valid1_r <= 1'b0;
    end
  end

  // Stage 2: operand push; an item meeting a low enable is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg_r  <= '0;
      w_reg_r  <= '0;
      valid2_r <= 1'b0;
    end else if (push_en) begin
      x_reg_r  <= rd_x_r;
      w_reg_r  <= rd_w_r;
      valid2_r <= valid1_r;
    end else begin
      valid2_r <= 1'b0;
    end
  end

  // Stage 3: wrapping accumulate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r <= '0;
    end else if (mac_en && valid2_r) begin
      acc_r <= acc_r + prod_ext_s;
    end else begin
      acc_r <= acc_r;
    end
  end

`ifdef ONE_NEURON_RELU_EN
  // Output ReLU: negative accumulator values read as zero
  always_comb begin
    if (acc_r[ACC_W-1]) begin
      mac_out = '0;
    end else begin
      mac_out = acc_r;
    end
  end
`else
  // Output is the raw two's-complement accumulator
  always_comb begin
    mac_out = acc_r;
  end
`endif

endmodule

// File: tb/tb_top_one_neuron.sv
// Self-checking bench for top_one_neuron: three parameterisations driven in lockstep,
// table-driven ramp plus hand-written reset/drop/stall sequences, queue scoreboard.
module tb_top_one_neuron;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, push_en, mac_en, mem_en;
  logic [17:0] out_a, out_b, out_c;

  top_one_neuron #(.N_INPUTS(16), .DATA_W(8), .ACC_W(18), .W_EVEN(3), .W_ODD(-1)) dut_a (
    .clk(clk), .reset(reset), .push_en(push_en), .mac_en(mac_en), .mem_en(mem_en), .mac_out(out_a));
  top_one_neuron #(.N_INPUTS(16), .DATA_W(8), .ACC_W(18), .W_EVEN(-1), .W_ODD(-1)) dut_b (
    .clk(clk), .reset(reset), .push_en(push_en), .mac_en(mac_en), .mem_en(mem_en), .mac_out(out_b));
  top_one_neuron #(.N_INPUTS(1), .DATA_W(8), .ACC_W(18), .W_EVEN(3), .W_ODD(-1)) dut_c (
    .clk(clk), .reset(reset), .push_en(push_en), .mac_en(mac_en), .mem_en(mem_en), .mac_out(out_c));

  typedef struct {
    logic mem;
    logic push;
    logic mac;
    int   exp_a;
    int   exp_b;
    int   exp_c;
  } vec_t;

  vec_t        vecs [30];
  logic [17:0] q_a [$];
  logic [17:0] q_b [$];
  logic [17:0] q_c [$];
  int          n_pass  = 0;
  int          n_total = 0;

  // Expected output view of an accumulator value
  function automatic logic [17:0] fold(input int v);
    logic [17:0] r;
    r = 18'(v);
`ifdef ONE_NEURON_RELU_EN
    if (r[17]) r = 18'd0;
`endif
    return r;
  endfunction

  // Dot product of indices 0..k (clamped to n items)
  function automatic int psum(input int k, input int n, input int we, input int wo);
    int s;
    s = 0;
    for (int i = 0; i <= k && i < n; i++) s += (i + 1) * (((i % 2) == 0) ? we : wo);
    return s;
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h", name, act, exp);
  endtask

  task automatic push_exp(input int a, input int b, input int c);
    q_a.push_back(fold(a));
    q_b.push_back(fold(b));
    q_c.push_back(fold(c));
  endtask

  task automatic tick_check(input string name);
    @(posedge clk);
    #1;
    if (q_a.size() == 0 || q_b.size() == 0 || q_c.size() == 0) begin
      n_total++;
      $display("FAIL %s_queue act=empty exp=entry", name);
    end else begin
      check({name, "_a"}, out_a, q_a.pop_front());
      check({name, "_b"}, out_b, q_b.pop_front());
      check({name, "_c"}, out_c, q_c.pop_front());
    end
  endtask

  // Reset with enables high (reset must win), release with the given enables
  task automatic do_reset(input logic m, input logic p, input logic c);
    reset   = 1'b1;
    mem_en  = 1'b1;
    push_en = 1'b1;
    mac_en  = 1'b1;
    #1;
    check("reset_async_a", out_a, 18'd0);
    check("reset_async_b", out_b, 18'd0);
    check("reset_async_c", out_c, 18'd0);
    for (int i = 0; i < 2; i++) begin
      push_exp(0, 0, 0);
      tick_check("reset_hold");
    end
    reset   = 1'b0;
    mem_en  = m;
    push_en = p;
    mac_en  = c;
  endtask

  initial begin
    reset   = 1'b1;
    mem_en  = 1'b0;
    push_en = 1'b0;
    mac_en  = 1'b0;
    @(posedge clk);
    #1;

    // Ramp: all enables high for 30 edges
    for (int e = 0; e < 30; e++)
      vecs[e] = '{1'b1, 1'b1, 1'b1, psum(e - 2, 16, 3, -1), psum(e - 2, 16, -1, -1),
                  psum(e - 2, 1, 3, -1)};
    do_reset(1'b1, 1'b1, 1'b1);
    for (int e = 0; e < 30; e++) begin
      mem_en  = vecs[e].mem;
      push_en = vecs[e].push;
      mac_en  = vecs[e].mac;
      push_exp(vecs[e].exp_a, vecs[e].exp_b, vecs[e].exp_c);
      tick_check($sformatf("ramp_e%0d", e));
    end
    check("ramp_final", out_a, 18'h00078);

    // Abort with reset at cycle 8, then a clean rerun
    do_reset(1'b1, 1'b1, 1'b1);
    for (int e = 0; e < 8; e++) begin
      push_exp(psum(e - 2, 16, 3, -1), psum(e - 2, 16, -1, -1), psum(e - 2, 1, 3, -1));
      tick_check("abort_pre");
    end
    reset = 1'b1;
    #1;
    check("abort_async_a", out_a, 18'd0);
    check("abort_async_b", out_b, 18'd0);
    push_exp(0, 0, 0);
    tick_check("abort_hold");
    reset = 1'b0;
    for (int e = 0; e < 20; e++) begin
      push_exp(psum(e - 2, 16, 3, -1), psum(e - 2, 16, -1, -1), psum(e - 2, 1, 3, -1));
      tick_check($sformatf("rerun_e%0d", e));
    end
    check("rerun_final", out_a, 18'd120);

    // push_en low at edge 3 drops index 2
    do_reset(1'b1, 1'b1, 1'b1);
    for (int e = 0; e < 22; e++) begin
      push_en = (e != 3);
      push_exp(psum(e - 2, 16, 3, -1) - ((e >= 4) ? 9 : 0),
               psum(e - 2, 16, -1, -1) + ((e >= 4) ? 3 : 0),
               psum(e - 2, 1, 3, -1));
      tick_check($sformatf("drop_e%0d", e));
    end
    check("drop_final", out_a, 18'd111);

    // mem_en held low for 10 edges, then raised
    do_reset(1'b0, 1'b1, 1'b1);
    for (int e = 0; e < 10; e++) begin
      push_exp(0, 0, 0);
      tick_check("stall");
    end
    mem_en = 1'b1;
    for (int e = 0; e < 22; e++) begin
      push_exp(psum(e - 2, 16, 3, -1), psum(e - 2, 16, -1, -1), psum(e - 2, 1, 3, -1));
      tick_check($sformatf("resume_e%0d", e));
    end
    check("resume_final", out_a, 18'd120);
    check("resume_final_b", out_b, fold(-136));
    check("resume_final_c", out_c, 18'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
